sram_manager_pipe: RTL and testbench

//  Parametrised successor to sram_manager: decodes load/store ops from the issue stage,

---
 rtl/sram_manager_pipe_if.sv | 24 ++
 rtl/sram_manager_pipe.sv | 173 +++++++++++++++++
 tb/tb_sram_manager_pipe.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_manager_pipe_if.sv
// sramc-side bus of sram_manager_pipe: word address, write data/enable out, read data back.
// master = the manager, slave = the SRAM controller.
interface sram_manager_pipe_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] memory_read;
   logic [DATA_WIDTH-1:0] memory_write;
   logic [31:0]           memory_address;
   logic                  memory_write_enable;

   modport master (
      input  memory_read,
      output memory_write,
      output memory_address,
      output memory_write_enable
   );

   modport slave (
      output memory_read,
      input  memory_write,
      input  memory_address,
      input  memory_write_enable
   );
endinterface

// File: rtl/sram_manager_pipe.sv
// sram_manager_pipe: fully pipelined load/store unit between issue stage, sramc and register files.
// Optional store-to-load forwarding is built when macro SRAM_FWD_EN is defined.
module sram_manager_pipe #(
   parameter int READ_LATENCY = 2,
   parameter int ADDR_WIDTH   = 20,
   parameter int DATA_WIDTH   = 32,
   parameter int REG_WIDTH    = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [31:0]            inst,
   input  logic [DATA_WIDTH-1:0]  rs,
   input  logic [DATA_WIDTH-1:0]  rt,
   input  logic [DATA_WIDTH-1:0]  imm,
   sram_manager_pipe_if.master    mem,
   output logic                   enable,
   output logic [REG_WIDTH-1:0]   addr,
   output logic [DATA_WIDTH-1:0]  data,
   output logic                   float
);

   localparam logic [5:0] OP_LDI  = 6'b101000;
   localparam logic [5:0] OP_STI  = 6'b101001;
   localparam logic [5:0] OP_LDR  = 6'b101100;
   localparam logic [5:0] OP_FLDI = 6'b101010;
   localparam logic [5:0] OP_FSTI = 6'b101011;
   localparam logic [5:0] OP_FLDR = 6'b101110;

   logic                  is_load;
   logic                  is_store;
   logic                  is_rform;
   logic                  is_float;
   logic [DATA_WIDTH-1:0] eff_sum;
   logic [ADDR_WIDTH-1:0] eff_addr;
   logic [REG_WIDTH-1:0]  issue_dest;

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      is_rform = 1'b0;
      is_float = 1'b0;
      case (inst[31:26])
         OP_LDI:  is_load = 1'b1;
         OP_STI:  is_store = 1'b1;
         OP_LDR:  begin is_load = 1'b1; is_rform = 1'b1; end
         OP_FLDI: begin is_load = 1'b1; is_float = 1'b1; end
         OP_FSTI: is_store = 1'b1;
         OP_FLDR: begin is_load = 1'b1; is_rform = 1'b1; is_float = 1'b1; end
         default: ;
      endcase
   end

   // Address wraps modulo 2**ADDR_WIDTH; upper sum bits are simply dropped.
   assign eff_sum    = rs + (is_rform ? rt : imm);
   assign eff_addr   = eff_sum[ADDR_WIDTH-1:0];
   assign issue_dest = is_rform ? REG_WIDTH'(inst[15:11]) : REG_WIDTH'(inst[20:16]);

   always_comb begin
      mem.memory_address      = '0;
      mem.memory_write        = '0;
      mem.memory_write_enable = 1'b0;
      if (reset && (is_load || is_store)) begin
         mem.memory_address      = 32'(eff_addr);
         mem.memory_write        = is_store ? rt : '0;
         mem.memory_write_enable = is_store;
      end
   end

   logic [READ_LATENCY-1:0] valid_q, valid_d;
   logic [READ_LATENCY-1:0] float_q, float_d;
   logic [REG_WIDTH-1:0]    dest_q [READ_LATENCY];
   logic [REG_WIDTH-1:0]    dest_d [READ_LATENCY];

   always_comb begin
      valid_d[0] = is_load;
      float_d[0] = is_float;
      dest_d[0]  = issue_dest;
      for (int i = 1; i < READ_LATENCY; i++) begin
         valid_d[i] = valid_q[i-1];
         float_d[i] = float_q[i-1];
         dest_d[i]  = dest_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         float_q <= '0;
         for (int i = 0; i < READ_LATENCY; i++) dest_q[i] <= '0;
      end else begin
         valid_q <= valid_d;
         float_q <= float_d;
         dest_q  <= dest_d;
      end
   end

   logic [DATA_WIDTH-1:0] load_data;

`ifdef SRAM_FWD_EN
   // Store history: entry 0 is the youngest store; the match is resolved at load issue.
   logic [READ_LATENCY-1:0] st_valid_q, st_valid_d;
   logic [ADDR_WIDTH-1:0]   st_addr_q [READ_LATENCY];
   logic [ADDR_WIDTH-1:0]   st_addr_d [READ_LATENCY];
   logic [DATA_WIDTH-1:0]   st_data_q [READ_LATENCY];
   logic [DATA_WIDTH-1:0]   st_data_d [READ_LATENCY];
   logic [READ_LATENCY-1:0] hit_q, hit_d;
   logic [DATA_WIDTH-1:0]   fdata_q [READ_LATENCY];
   logic [DATA_WIDTH-1:0]   fdata_d [READ_LATENCY];
   logic                    issue_hit;
   logic [DATA_WIDTH-1:0]   issue_fdata;

   always_comb begin
      issue_hit   = 1'b0;
      issue_fdata = '0;
      for (int i = READ_LATENCY - 1; i >= 0; i--) begin
         if (st_valid_q[i] && st_addr_q[i] == eff_addr) begin
            issue_hit   = 1'b1;
            issue_fdata = st_data_q[i];
         end
      end
   end

   always_comb begin
      st_valid_d = st_valid_q;
      st_addr_d  = st_addr_q;
      st_data_d  = st_data_q;
      if (is_store) begin
         st_valid_d[0] = 1'b1;
         st_addr_d[0]  = eff_addr;
         st_data_d[0]  = rt;
         for (int i = 1; i < READ_LATENCY; i++) begin
            st_valid_d[i] = st_valid_q[i-1];
            st_addr_d[i]  = st_addr_q[i-1];
            st_data_d[i]  = st_data_q[i-1];
         end
      end
      hit_d[0]   = is_load && issue_hit;
      fdata_d[0] = issue_fdata;
      for (int i = 1; i < READ_LATENCY; i++) begin
         hit_d[i]   = hit_q[i-1];
         fdata_d[i] = fdata_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_valid_q <= '0;
         hit_q      <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            st_addr_q[i] <= '0;
            st_data_q[i] <= '0;
            fdata_q[i]   <= '0;
         end
      end else begin
         st_valid_q <= st_valid_d;
         st_addr_q  <= st_addr_d;
         st_data_q  <= st_data_d;
         hit_q      <= hit_d;
         fdata_q    <= fdata_d;
      end
   end

   assign load_data = hit_q[READ_LATENCY-1] ? fdata_q[READ_LATENCY-1] : mem.memory_read;
`else
   assign load_data = mem.memory_read;
`endif

   assign enable = valid_q[READ_LATENCY-1];
   assign addr   = enable ? dest_q[READ_LATENCY-1] : '0;
   assign float  = enable ? float_q[READ_LATENCY-1] : 1'b0;
   assign data   = enable ? load_data : '0;

endmodule

// File: tb/tb_sram_manager_pipe.sv
// Directed testbench for sram_manager_pipe with a READ_LATENCY=2 sramc model.
// The forwarding scenario is compiled only when SRAM_FWD_EN is defined.
module tb_sram_manager_pipe;

   localparam int RL = 2;

   localparam logic [5:0] LDI  = 6'b101000;
   localparam logic [5:0] STI  = 6'b101001;
   localparam logic [5:0] LDR  = 6'b101100;
   localparam logic [5:0] FLDI = 6'b101010;
   localparam logic [5:0] FSTI = 6'b101011;
   localparam logic [5:0] NOP  = 6'b000000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] inst = '0;
   logic [31:0] rs = '0;
   logic [31:0] rt = '0;
   logic [31:0] imm = '0;
   logic        enable;
   logic [4:0]  addr;
   logic [31:0] data;
   logic        flt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   sram_manager_pipe_if #(.DATA_WIDTH(32)) mem_if ();

   sram_manager_pipe #(
      .READ_LATENCY(RL),
      .ADDR_WIDTH(20),
      .DATA_WIDTH(32),
      .REG_WIDTH(5)
   ) dut (
      .clk(clk),
      .reset(reset),
      .inst(inst),
      .rs(rs),
      .rt(rt),
      .imm(imm),
      .mem(mem_if),
      .enable(enable),
      .addr(addr),
      .data(data),
      .float(flt)
   );

   // sramc model: address captured at edge 1, data registered out at edge 2.
   logic [31:0] mem [0:1023];
   logic [9:0]  rd_a = '0;
   logic [31:0] mem_rd = '0;
   logic        stuck = 1'b0;

   always @(posedge clk) begin
      mem_rd <= stuck ? 32'd0 : mem[rd_a];
      rd_a   <= mem_if.memory_address[9:0];
      if (mem_if.memory_write_enable) mem[mem_if.memory_address[9:0]] <= mem_if.memory_write;
   end
   assign mem_if.memory_read = mem_rd;

   typedef struct {
      int          cyc;
      logic [4:0]  a;
      logic        f;
      logic [31:0] d;
   } wb_t;

   wb_t wbq[$];
   int  cyc = 0;
   int  idle_bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (enable) wbq.push_back('{cyc, addr, flt, data});
      else if (addr != 5'd0 || flt || data != 32'd0) idle_bad <= idle_bad + 1;
   end

   task automatic applyStimulus(input logic [5:0] op, input logic [4:0] d16, input logic [4:0] d11,
                                input logic [31:0] a_rs, input logic [31:0] a_rt, input logic [31:0] a_imm);
      inst = {op, 5'd0, d16, d11, 11'd0};
      rs   = a_rs;
      rt   = a_rt;
      imm  = a_imm;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      inst = '0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic test_reset();
      applyStimulus(STI, 5'd0, 5'd0, 32'd5, 32'd10, 32'd15);
      tests++; if (mem_if.memory_write_enable !== 1'b0) begin fails++; $display("[TB] FAIL reset_we got %0b want 0", mem_if.memory_write_enable); end
      tests++; if (mem_if.memory_address !== 32'd0) begin fails++; $display("[TB] FAIL reset_maddr got %0d want 0", mem_if.memory_address); end
      tests++; if (mem_if.memory_write !== 32'd0) begin fails++; $display("[TB] FAIL reset_mwrite got %0d want 0", mem_if.memory_write); end
      tests++; if ({enable, addr, flt, data} !== 39'd0) begin fails++; $display("[TB] FAIL reset_wb got en=%0b a=%0d f=%0b d=%0d want all 0", enable, addr, flt, data); end
      step();
      reset = 1'b1;
      idle(1);
   endtask

   task automatic test_store_load_int();
      int n0, k;
      applyStimulus(STI, 5'd0, 5'd0, 32'd5, 32'd10, 32'd15);
      tests++; if (mem_if.memory_address !== 32'd20 || mem_if.memory_write_enable !== 1'b1 || mem_if.memory_write !== 32'd10)
         begin fails++; $display("[TB] FAIL sti_bus got a=%0d we=%0b w=%0d want a=20 we=1 w=10", mem_if.memory_address, mem_if.memory_write_enable, mem_if.memory_write); end
      step();
      idle(1);
      n0 = wbq.size();
      applyStimulus(LDI, 5'd2, 5'd0, 32'd5, 32'd10, 32'd15);
      tests++; if (mem_if.memory_address !== 32'd20 || mem_if.memory_write_enable !== 1'b0)
         begin fails++; $display("[TB] FAIL ldi_bus got a=%0d we=%0b want a=20 we=0", mem_if.memory_address, mem_if.memory_write_enable); end
      step();
      k = cyc;
      idle(RL + 2);
      tests++;
      if (wbq.size() - n0 != 1) begin fails++; $display("[TB] FAIL ldi_count got %0d want 1", wbq.size() - n0); end
      else if (wbq[n0].a !== 5'd2 || wbq[n0].f !== 1'b0 || wbq[n0].d !== 32'd10 || wbq[n0].cyc != k + RL - 1)
         begin fails++; $display("[TB] FAIL ldi_wb got a=%0d f=%0b d=%0d cyc=%0d want a=2 f=0 d=10 cyc=%0d", wbq[n0].a, wbq[n0].f, wbq[n0].d, wbq[n0].cyc, k + RL - 1); end
   endtask

   task automatic test_store_load_float();
      int n0;
      applyStimulus(FSTI, 5'd0, 5'd0, 32'd5, 32'd30, 32'd25);
      step();
      idle(1);
      n0 = wbq.size();
      applyStimulus(FLDI, 5'd2, 5'd0, 32'd5, 32'd0, 32'd25);
      step();
      idle(RL + 2);
      tests++;
      if (wbq.size() - n0 != 1) begin fails++; $display("[TB] FAIL fldi_count got %0d want 1", wbq.size() - n0); end
      else if (wbq[n0].a !== 5'd2 || wbq[n0].f !== 1'b1 || wbq[n0].d !== 32'd30)
         begin fails++; $display("[TB] FAIL fldi_wb got a=%0d f=%0b d=%0d want a=2 f=1 d=30", wbq[n0].a, wbq[n0].f, wbq[n0].d); end
   endtask

   task automatic test_load_rform();
      int n0;
      n0 = wbq.size();
      applyStimulus(LDR, 5'd7, 5'd2, 32'd5, 32'd15, 32'd99);
      tests++; if (mem_if.memory_address !== 32'd20) begin fails++; $display("[TB] FAIL ldr_addr got %0d want 20", mem_if.memory_address); end
      step();
      idle(RL + 2);
      tests++;
      if (wbq.size() - n0 != 1) begin fails++; $display("[TB] FAIL ldr_count got %0d want 1", wbq.size() - n0); end
      else if (wbq[n0].a !== 5'd2 || wbq[n0].f !== 1'b0 || wbq[n0].d !== 32'd10)
         begin fails++; $display("[TB] FAIL ldr_wb got a=%0d f=%0b d=%0d want a=2 f=0 d=10", wbq[n0].a, wbq[n0].f, wbq[n0].d); end
   endtask

   task automatic test_back_to_back();
      int n0;
      n0 = wbq.size();
      applyStimulus(STI, 5'd0, 5'd0, 32'd0, 32'd9, 32'd20);  step();
      applyStimulus(STI, 5'd0, 5'd0, 32'd0, 32'd10, 32'd21); step();
      applyStimulus(LDI, 5'd3, 5'd0, 32'd0, 32'd0, 32'd20);  step();
      applyStimulus(LDI, 5'd4, 5'd0, 32'd0, 32'd0, 32'd21);  step();
      applyStimulus(STI, 5'd0, 5'd0, 32'd0, 32'h77, 32'd50); step();
      applyStimulus(LDI, 5'd6, 5'd0, 32'd0, 32'd0, 32'd50);  step();
      applyStimulus(6'b101111, 5'd8, 5'd8, 32'd0, 32'd1, 32'd20);
      tests++; if (mem_if.memory_write_enable !== 1'b0) begin fails++; $display("[TB] FAIL nop_we got %0b want 0", mem_if.memory_write_enable); end
      step();
      idle(RL + 2);
      tests++;
      if (wbq.size() - n0 != 3) begin fails++; $display("[TB] FAIL b2b_count got %0d want 3", wbq.size() - n0); end
      else if (wbq[n0].a !== 5'd3 || wbq[n0].d !== 32'd9 || wbq[n0+1].a !== 5'd4 || wbq[n0+1].d !== 32'd10 || wbq[n0+1].cyc != wbq[n0].cyc + 1)
         begin fails++; $display("[TB] FAIL b2b_wb got a=%0d d=%0d c=%0d / a=%0d d=%0d c=%0d want 3,9 then 4,10 consecutive", wbq[n0].a, wbq[n0].d, wbq[n0].cyc, wbq[n0+1].a, wbq[n0+1].d, wbq[n0+1].cyc); end
      else if (wbq[n0+2].a !== 5'd6 || wbq[n0+2].d !== 32'h77)
         begin fails++; $display("[TB] FAIL st_ld_adjacent got a=%0d d=%0h want a=6 d=77", wbq[n0+2].a, wbq[n0+2].d); end
   endtask

   task automatic test_wrap();
      int n0;
      applyStimulus(STI, 5'd0, 5'd0, 32'h000F_FFFF, 32'd7, 32'd2);
      tests++; if (mem_if.memory_address !== 32'd1) begin fails++; $display("[TB] FAIL wrap_addr got %0h want 1", mem_if.memory_address); end
      step();
      idle(1);
      n0 = wbq.size();
      applyStimulus(LDI, 5'd5, 5'd0, 32'h000F_FFFF, 32'd0, 32'd2);
      step();
      idle(RL + 2);
      tests++;
      if (wbq.size() - n0 != 1 || wbq[n0].a !== 5'd5 || wbq[n0].d !== 32'd7)
         begin fails++; $display("[TB] FAIL wrap_wb got n=%0d want one writeback a=5 d=7", wbq.size() - n0); end
   endtask

   task automatic test_reset_mid();
      int n0;
      n0 = wbq.size();
      applyStimulus(LDI, 5'd7, 5'd0, 32'd0, 32'd0, 32'd20);
      step();
      reset = 1'b0;
      applyStimulus(STI, 5'd0, 5'd0, 32'd0, 32'd3, 32'd20);
      tests++; if (mem_if.memory_write_enable !== 1'b0 || mem_if.memory_address !== 32'd0)
         begin fails++; $display("[TB] FAIL rst_mid_bus got we=%0b a=%0d want 0 0", mem_if.memory_write_enable, mem_if.memory_address); end
      step();
      tests++; if ({enable, addr, flt, data} !== 39'd0)
         begin fails++; $display("[TB] FAIL rst_mid_wb got en=%0b a=%0d d=%0d want all 0", enable, addr, data); end
      reset = 1'b1;
      idle(RL + 2);
      tests++; if (wbq.size() != n0) begin fails++; $display("[TB] FAIL rst_drop got %0d writebacks want 0", wbq.size() - n0); end
      applyStimulus(LDI, 5'd8, 5'd0, 32'd0, 32'd0, 32'd21);
      step();
      idle(RL + 2);
      tests++;
      if (wbq.size() - n0 != 1 || wbq[n0].a !== 5'd8 || wbq[n0].d !== 32'd10)
         begin fails++; $display("[TB] FAIL rst_after got n=%0d want one writeback a=8 d=10", wbq.size() - n0); end
   endtask

`ifdef SRAM_FWD_EN
   task automatic test_forward();
      int n0;
      stuck = 1'b1;
      n0 = wbq.size();
      applyStimulus(STI, 5'd0, 5'd0, 32'd0, 32'h55, 32'd40); step();
      applyStimulus(LDI, 5'd9, 5'd0, 32'd0, 32'd0, 32'd40);  step();
      idle(RL + 2);
      tests++;
      if (wbq.size() - n0 != 1 || wbq[n0].a !== 5'd9 || wbq[n0].d !== 32'h55)
         begin fails++; $display("[TB] FAIL fwd got n=%0d want one writeback a=9 d=55", wbq.size() - n0); end
      stuck = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_store_load_int();
      test_store_load_float();
      test_load_rform();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
`ifdef SRAM_FWD_EN
      test_forward();
`endif
      tests++; if (idle_bad != 0) begin fails++; $display("[TB] FAIL idle_zero got %0d nonzero idle cycles want 0", idle_bad); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
